lcd_nibble_writer: RTL and testbench

- Downstream consumer of the 4-bit Avalon-MM output PIO.
- Takes the PIO nibble plus RS and start bits from a second control PIO, and generates one HD44780-compatible 4-bit-mode write cycle on the LCD pins: setup, E pulse, hold, then a command execution gap.
- Exposes busy/done so firmware can poll completion through an input PIO.

---
 rtl/lcd_pkg.sv | 19 +
 rtl/lcd_phase_counter.sv | 28 ++
 rtl/lcd_nibble_writer.sv | 138 +++++++++++++
 tb/tb_lcd_nibble_writer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and 50 MHz timing defaults for the HD44780 4-bit nibble writer.
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        EN_HI,
        HOLD,
        GAP
    } state_t;

    // Defaults in 50 MHz clk cycles: 60 ns setup, 240 ns E pulse, 20 ns hold, 40 us execution gap.
    localparam int unsigned SETUP_CYC_DEF = 3;
    localparam int unsigned EN_CYC_DEF    = 12;
    localparam int unsigned HOLD_CYC_DEF  = 1;
    localparam int unsigned GAP_CYC_DEF   = 2000;
    localparam int unsigned CNT_W_DEF     = 16;

endpackage

// File: rtl/lcd_phase_counter.sv
// Loadable down-counter shared by all write-cycle phases; saturates at zero.
module lcd_phase_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/lcd_nibble_writer.sv
// Turns a PIO nibble plus RS/start into one HD44780 4-bit write cycle with busy/done status.
module lcd_nibble_writer
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC = SETUP_CYC_DEF,
    parameter int unsigned EN_CYC    = EN_CYC_DEF,
    parameter int unsigned HOLD_CYC  = HOLD_CYC_DEF,
    parameter int unsigned GAP_CYC   = GAP_CYC_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] nibble_in,
    input  logic       rs_in,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [3:0] lcd_d,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e
);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);

    state_t           state, state_next;
    logic             start_q;
    logic             request;
    logic             e_next, busy_next, done_next;
    logic             latch;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_val;

    assign request = start && !start_q;
    assign lcd_rw  = 1'b0;

    lcd_phase_counter #(
        .CNT_W (CNT_W)
    ) u_phase_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        e_next     = lcd_e;
        busy_next  = busy;
        done_next  = 1'b0;
        latch      = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        cnt_val    = '0;

        unique case (state)
            IDLE: begin
                if (request) begin
                    latch      = 1'b1;
                    busy_next  = 1'b1;
                    cnt_load   = 1'b1;
                    cnt_val    = SETUP_LD;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    e_next     = 1'b1;
                    cnt_load   = 1'b1;
                    cnt_val    = EN_LD;
                    state_next = EN_HI;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            EN_HI: begin
                if (cnt_zero) begin
                    e_next     = 1'b0;
                    cnt_load   = 1'b1;
                    cnt_val    = HOLD_LD;
                    state_next = HOLD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            HOLD: begin
                if (cnt_zero) begin
                    cnt_load   = 1'b1;
                    cnt_val    = GAP_LD;
                    state_next = GAP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            GAP: begin
                // A start edge arriving on this final edge is dropped: the state is still GAP here.
                if (cnt_zero) begin
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the asynchronous reset clears lcd_e at once, aborting any transfer in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            start_q <= 1'b0;
            lcd_e   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            lcd_d   <= 4'h0;
            lcd_rs  <= 1'b0;
        end else begin
            state   <= state_next;
            start_q <= start;
            lcd_e   <= e_next;
            busy    <= busy_next;
            done    <= done_next;
            if (latch) begin
                lcd_d  <= nibble_in;
                lcd_rs <= rs_in;
            end
        end
    end

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Self-checking bench for lcd_nibble_writer: edge-indexed timing model, vector table, directed corners, random start traffic.
module tb_lcd_nibble_writer;

    localparam int SETUP = 3;
    localparam int EN    = 12;
    localparam int HOLD  = 1;
    localparam int GAP   = 2000;
    localparam int TOTAL = SETUP + EN + HOLD + GAP;

    logic       clk;
    logic       reset_n;
    logic [3:0] nibble_in;
    logic       rs_in;
    logic       start;
    logic       busy, done, lcd_rs, lcd_rw, lcd_e;
    logic [3:0] lcd_d;

    lcd_nibble_writer #(
        .SETUP_CYC (SETUP),
        .EN_CYC    (EN),
        .HOLD_CYC  (HOLD),
        .GAP_CYC   (GAP),
        .CNT_W     (16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .nibble_in (nibble_in),
        .rs_in     (rs_in),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .lcd_d     (lcd_d),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_e     (lcd_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a transfer accepted at edge k fixes every output as a function of (edge - k).
    bit         m_have;
    longint     m_e = 0;
    longint     m_k;
    logic [3:0] m_nib;
    logic       m_rs;
    logic       m_sp;

    task automatic model_reset();
        m_have = 1'b0;
        m_nib  = 4'h0;
        m_rs   = 1'b0;
        m_sp   = 1'b0;
    endtask

    task automatic model_edge();
        bit req;
        m_e++;
        if (!reset_n) begin
            model_reset();
        end else begin
            req  = start && !m_sp;
            m_sp = start;
            if (req && (!m_have || m_e >= m_k + TOTAL + 1)) begin
                m_have = 1'b1;
                m_k    = m_e;
                m_nib  = nibble_in;
                m_rs   = rs_in;
            end
        end
    endtask

    function automatic logic [15:0] exp_vec();
        logic b, e, d;
        b = m_have && (m_e >= m_k) && (m_e < m_k + TOTAL);
        e = m_have && (m_e >= m_k + SETUP) && (m_e < m_k + SETUP + EN);
        d = m_have && (m_e == m_k + TOTAL);
        return {7'b0, 1'b0, d, b, e, m_rs, m_nib};
    endfunction

    function automatic logic [15:0] dut_vec();
        return {7'b0, lcd_rw, done, busy, lcd_e, lcd_rs, lcd_d};
    endfunction

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check(tag, dut_vec(), exp_vec());
    endtask

    typedef struct {
        int         off;
        logic       e;
        logic       busy;
        logic       done;
        logic [3:0] d;
        logic       rs;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{0,    1'b0, 1'b1, 1'b0, 4'hA, 1'b1};
        tbl[1]  = '{2,    1'b0, 1'b1, 1'b0, 4'hA, 1'b1};
        tbl[2]  = '{3,    1'b1, 1'b1, 1'b0, 4'hA, 1'b1};
        tbl[3]  = '{8,    1'b1, 1'b1, 1'b0, 4'hA, 1'b1};
        tbl[4]  = '{14,   1'b1, 1'b1, 1'b0, 4'hA, 1'b1};
        tbl[5]  = '{15,   1'b0, 1'b1, 1'b0, 4'hA, 1'b1};
        tbl[6]  = '{16,   1'b0, 1'b1, 1'b0, 4'hA, 1'b1};
        tbl[7]  = '{2015, 1'b0, 1'b1, 1'b0, 4'hA, 1'b1};
        tbl[8]  = '{2016, 1'b0, 1'b0, 1'b1, 4'hA, 1'b1};
        tbl[9]  = '{2017, 1'b0, 1'b0, 1'b0, 4'hA, 1'b1};
        tbl[10] = '{2030, 1'b0, 1'b0, 1'b0, 4'hA, 1'b1};

        model_reset();
        reset_n   = 1'b0;
        start     = 1'b0;
        nibble_in = 4'hF;
        rs_in     = 1'b1;

        // Reset held with start toggling: everything stays at zero.
        for (int i = 0; i < 6; i++) begin
            start = ~start;
            step("reset_hold");
        end
        check("reset_zero", dut_vec(), 16'h0000);
        start   = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) step("idle");

        // Basic write, data stability, busy rejection, start held high across done.
        nibble_in = 4'hA;
        rs_in     = 1'b1;
        start     = 1'b1;
        for (int off = 0; off <= 2030; off++) begin
            step("basic");
            foreach (tbl[i]) begin
                if (tbl[i].off == off)
                    check($sformatf("basic_tbl_off%0d", off), dut_vec(),
                          {7'b0, 1'b0, tbl[i].done, tbl[i].busy, tbl[i].e, tbl[i].rs, tbl[i].d});
            end
            if (off == 8) begin
                nibble_in = 4'h5;
                rs_in     = 1'b0;
            end
            if (off == 100) start = 1'b0;
            if (off == 101) start = 1'b1;
        end

        // Fresh low->high after done: second transfer latches the new nibble.
        start = 1'b0;
        step("rearm");
        start = 1'b1;
        step("relatch");
        check("relatch_d", {11'b0, busy, lcd_d}, {11'b0, 1'b1, 4'h5});
        for (int off = 1; off <= 2015; off++) begin
            step("xfer2");
            if (off == 3) start = 1'b0;
        end
        // Start edge landing on the done edge is ignored.
        start = 1'b1;
        step("done_edge");
        check("done_edge_pulse", {14'b0, done, busy}, 16'h0002);
        for (int i = 0; i < 5; i++) step("done_edge_after");
        check("done_edge_ignored", {14'b0, busy, lcd_e}, 16'h0000);

        // Start edge on the first idle edge after done is accepted.
        start = 1'b0;
        step("rearm3");
        start = 1'b1;
        for (int off = 0; off <= 2016; off++) begin
            step("xfer3");
            if (off == 3) start = 1'b0;
        end
        check("xfer3_done", {15'b0, done}, 16'h0001);
        start = 1'b1;
        step("b2b");
        check("b2b_accept", {15'b0, busy}, 16'h0001);
        for (int off = 1; off <= 8; off++) step("pre_reset");
        check("pre_reset_e", {15'b0, lcd_e}, 16'h0001);

        // Asynchronous reset while E is high.
        #2 reset_n = 1'b0;
        #1;
        check("async_reset", {13'b0, done, busy, lcd_e}, 16'h0000);
        model_reset();
        step("in_reset");
        step("in_reset");
        start   = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) step("post_reset_idle");
        check("post_reset_idle_busy", {14'b0, busy, lcd_e}, 16'h0000);
        begin
            int done_cnt = 0;
            nibble_in = 4'h3;
            rs_in     = 1'b0;
            start     = 1'b1;
            for (int off = 0; off <= TOTAL + 2; off++) begin
                step("post_reset_xfer");
                if (done) done_cnt++;
            end
            check("post_reset_done_once", 16'(done_cnt), 16'd1);
        end

        // Random start traffic with changing data, checked cycle by cycle.
        for (int i = 0; i < 8000; i++) begin
            if ($urandom_range(0, 149) == 0) start = ~start;
            nibble_in = 4'($urandom);
            rs_in     = 1'($urandom);
            step("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
